fifo_overflow_mp: RTL and testbench
===================================

// Module: fifo_overflow_mp
// PURPOSE
//  Multi-port circular FIFO with per-cycle multi-push / multi-pop and a selectable full policy:
//  overwrite-oldest (lossy trace/history queues) or backpressure (lossless issue/commit queues).
//  Generalises the single-port overflow FIFO to PUSH_W writers and POP_W readers per cycle.
//  Adds free-slot reporting, an overflow pulse and a saturating drop counter.
//  Sits between wide-issue front-end stages and vector/scalar consumers; flushable on mispredict.
// PARAMETERS
//  DW        16  data width per entry
//  DEPTH     8   entries; power of two, >= 2
//  PUSH_W    2   push lanes per cycle, 1..DEPTH
//  POP_W     2   pop lanes per cycle, 1..DEPTH
//  OVERWRITE 1   1: full FIFO overwrites oldest entries; 0: backpressure via push_ready
//  CNT_W     8   width of drop_cnt
// PORTS
//  clk        in   1                      clock, all state on posedge
//  rst        in   1                      synchronous reset, active-high
//  flush      in   1                      synchronous empty; priority over push/pop
//  push_valid in   PUSH_W                 lane valids; must be contiguous from lane 0 (thermometer)
//  push_data  in   PUSH_W*DW              lane i data, oldest = lane 0
//  push_ready out  PUSH_W                 lane i accepted this cycle
//  pop_cnt    in   $clog2(POP_W+1)        entries consumed this cycle, 0..POP_W
//  pop_data   out  POP_W*DW               lane i = i-th oldest entry
//  valid      out  POP_W                  lane i holds data (count > i)
//  free_slots out  $clog2(DEPTH+1)        DEPTH - count
//  overflow   out  1                      pulse: >=1 entry overwritten/lost this cycle
//  drop_cnt   out  CNT_W                  saturating total of overwritten entries
// BEHAVIOUR
//  - State: mem (not reset), head, tail ($clog2(DEPTH) bits, natural wrap), count (0..DEPTH), drop_cnt.
//  - Reset: head=tail=count=0; valid=0; overflow=0; drop_cnt=0; push_ready = all-ones if OVERWRITE
//    else lanes i < DEPTH; pop_data don't-care while lane invalid.
//  - Outputs valid/pop_data/free_slots/push_ready depend only on registered state (no in->out paths).
//  - Read: pop_data[i] = mem[head+i] combinationally; valid[i] = (count > i).
//  - Latency: data pushed in cycle t visible on pop_data in t+1; no write-to-read bypass.
//  - Per cycle: n_pop = pop_cnt; n_push = popcount(push_valid & push_ready). Pop applied first, then push.
//  - pop_cnt > count is illegal (assertion, $fatal); non-thermometer push_valid is illegal (assertion).
//  - OVERWRITE=0: push_ready[i] = (i < free_slots); pops of this cycle do NOT free slots for this
//    cycle's pushes. Rejected lanes are the producer's to hold. overflow=0, drop_cnt stays 0.
//  - OVERWRITE=1: push_ready all-ones. raw = count - n_pop + n_push; if raw > DEPTH:
//    excess = raw - DEPTH; head += n_pop + excess; count = DEPTH; overflow=1 for one cycle;
//    drop_cnt += excess, saturating at 2^CNT_W-1. Else head += n_pop, count = raw.
//  - Write: lane i (accepted) stored at mem[tail+i]; tail += n_push. Lanes written in lane order,
//    so when n_push > DEPTH-only case can't occur (PUSH_W <= DEPTH) no lane aliases another.
//  - Simultaneous pop and push at full: OVERWRITE=0 push limited to free_slots (0), pop proceeds;
//    OVERWRITE=1 pop frees slots first, overflow only on the remainder.
//  - Wrap-around: head/tail modulo DEPTH via bit truncation; count disambiguates full vs empty.
//  - flush: next cycle head=tail=count=0, overflow=0; drop_cnt preserved; same-cycle push/pop ignored.
//  - rst mid-operation: all state per reset values next cycle regardless of push/pop/flush.
// TESTING
//  DW=8 DEPTH=8 PUSH_W=2 POP_W=2 unless stated.
//  1 Fill/drain: 4 cycles push 2 lanes (0x00..0x07), then pop_cnt=2 x4 -> pop order 00..07,
//    free_slots 8,6,4,2,0 then back to 8; valid=2'b11 until empty, then 2'b00.
//  2 Overwrite: OVERWRITE=1, full with 00..07, push 2 (AA,BB), pop_cnt=0 -> overflow pulse 1 cycle,
//    drop_cnt=2, pop_data = {03,02}... lane0=02, lane1=03; final entries 02..07,AA,BB.
//  3 Full with pop: OVERWRITE=1, full, push 2 + pop_cnt=1 -> overflow=1, drop_cnt+=1, count stays 8.
//  4 Backpressure: OVERWRITE=0, 7 entries, push 2 lanes -> push_ready=2'b01, only lane0 stored,
//    free_slots=0 next; with pop_cnt=2 same cycle push_ready still 2'b01.
//  5 Wrap: 1000 random cycles of random push/pop with head/tail wrapping -> matches queue
//    scoreboard; drop_cnt with CNT_W=2 saturates at 3.
//  6 Flush/reset: flush with push_valid=2'b11 at count=5 -> count 0, valid=0, drop_cnt unchanged;
//    rst mid-stream -> all reset values, drop_cnt=0.

Source files
------------

// File: rtl/fifo_overflow_mp.sv
// Multi-port circular FIFO with per-cycle multi-push/multi-pop.
// Full policy is either overwrite-oldest (lossy) or backpressure (lossless).
module fifo_overflow_mp #(
  parameter int DW        = 16,
  parameter int DEPTH     = 8,
  parameter int PUSH_W    = 2,
  parameter int POP_W     = 2,
  parameter int OVERWRITE = 1,
  parameter int CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [PUSH_W-1:0]            push_valid,
  input  logic [PUSH_W*DW-1:0]         push_data,
  output logic [PUSH_W-1:0]            push_ready,
  input  logic [$clog2(POP_W+1)-1:0]   pop_cnt,
  output logic [POP_W*DW-1:0]          pop_data,
  output logic [POP_W-1:0]             valid,
  output logic [$clog2(DEPTH+1)-1:0]   free_slots,
  output logic                         overflow,
  output logic [CNT_W-1:0]             drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = CW + 1;
  localparam int SW = ((CNT_W > RW) ? CNT_W : RW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [PUSH_W-1:0] accept;
  logic [RW-1:0]     n_push, n_pop, raw, excess;
  logic [SW-1:0]     drop_sum;

  // All outputs come from registered state only.
  always_comb begin
    free_slots = CW'(DEPTH) - count_q;
    for (int i = 0; i < PUSH_W; i++) begin
      push_ready[i] = (OVERWRITE != 0) || (CW'(i) < (CW'(DEPTH) - count_q));
    end
    for (int i = 0; i < POP_W; i++) begin
      valid[i]              = count_q > CW'(i);
      pop_data[i*DW +: DW]  = mem_q[head_q + AW'(i)];
    end
    overflow = overflow_q;
    drop_cnt = drop_cnt_q;
  end

  always_comb begin
    accept = push_valid & push_ready;
    n_push = '0;
    for (int i = 0; i < PUSH_W; i++) begin
      n_push = n_push + RW'(accept[i]);
    end
    n_pop  = RW'(pop_cnt);
    raw    = RW'(count_q) - n_pop + n_push;
    excess = '0;
    if ((OVERWRITE != 0) && (raw > RW'(DEPTH))) begin
      excess = raw - RW'(DEPTH);
    end
    drop_sum = SW'(drop_cnt_q) + SW'(excess);

    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    drop_cnt_d = drop_cnt_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Overwritten entries are retired by advancing head past them.
      head_d     = head_q + AW'(n_pop + excess);
      tail_d     = tail_q + AW'(n_push);
      count_d    = CW'(raw - excess);
      overflow_d = (excess != '0);
      drop_cnt_d = (drop_sum > SW'(CNT_MAX)) ? CNT_MAX : CNT_W'(drop_sum);
      for (int i = 0; i < PUSH_W; i++) begin
        if (accept[i]) begin
          mem_d[tail_q + AW'(i)] = push_data[i*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (RW'(pop_cnt) <= RW'(count_q))
        else $fatal(1, "pop_cnt exceeds occupancy");
      assert ((push_valid & (push_valid + PUSH_W'(1))) == '0)
        else $error("push_valid is not contiguous from lane 0");
    end
  end
`endif

endmodule

// File: tb/tb_fifo_overflow_mp.sv
// Randomised bench for fifo_overflow_mp: one backpressure and one overwrite instance,
// each compared against a queue-based reference model.
module tb_fifo_overflow_mp;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        bp_flush, ow_flush;
  logic [1:0]  bp_push_valid, ow_push_valid;
  logic [15:0] bp_push_data, ow_push_data;
  logic [1:0]  bp_push_ready, ow_push_ready;
  logic [1:0]  bp_pop_cnt, ow_pop_cnt;
  logic [15:0] bp_pop_data, ow_pop_data;
  logic [1:0]  bp_valid, ow_valid;
  logic [3:0]  bp_free_slots, ow_free_slots;
  logic        bp_overflow, ow_overflow;
  logic [7:0]  bp_drop_cnt;
  logic [1:0]  ow_drop_cnt;

  fifo_overflow_mp #(
    .DW(8), .DEPTH(DEPTH), .PUSH_W(2), .POP_W(2), .OVERWRITE(0), .CNT_W(8)
  ) dut_bp (
    .clk(clk), .rst(rst), .flush(bp_flush),
    .push_valid(bp_push_valid), .push_data(bp_push_data), .push_ready(bp_push_ready),
    .pop_cnt(bp_pop_cnt), .pop_data(bp_pop_data), .valid(bp_valid),
    .free_slots(bp_free_slots), .overflow(bp_overflow), .drop_cnt(bp_drop_cnt)
  );

  fifo_overflow_mp #(
    .DW(8), .DEPTH(DEPTH), .PUSH_W(2), .POP_W(2), .OVERWRITE(1), .CNT_W(2)
  ) dut_ow (
    .clk(clk), .rst(rst), .flush(ow_flush),
    .push_valid(ow_push_valid), .push_data(ow_push_data), .push_ready(ow_push_ready),
    .pop_cnt(ow_pop_cnt), .pop_data(ow_pop_data), .valid(ow_valid),
    .free_slots(ow_free_slots), .overflow(ow_overflow), .drop_cnt(ow_drop_cnt)
  );

  // Reference model: contents as a plain queue, oldest at index 0.
  bit         ow_sel;
  logic [7:0] mq[$];
  int         mdrop;
  bit         movf;
  int         checks;
  int         errors;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic idleInputs();
    bp_flush = 1'b0; bp_push_valid = 2'b00; bp_push_data = '0; bp_pop_cnt = 2'd0;
    ow_flush = 1'b0; ow_push_valid = 2'b00; ow_push_data = '0; ow_pop_cnt = 2'd0;
  endtask

  task automatic checkState();
    logic [1:0]  v, exp_v;
    logic [15:0] pd;
    logic [3:0]  fs;
    logic        ov;
    logic [7:0]  dc;
    if (ow_sel) begin
      v = ow_valid; pd = ow_pop_data; fs = ow_free_slots; ov = ow_overflow; dc = {6'b0, ow_drop_cnt};
    end else begin
      v = bp_valid; pd = bp_pop_data; fs = bp_free_slots; ov = bp_overflow; dc = bp_drop_cnt;
    end
    exp_v[0] = (mq.size() > 0);
    exp_v[1] = (mq.size() > 1);
    checkOutput("valid", 32'(v), 32'(exp_v));
    if (mq.size() > 0) checkOutput("pop_data0", 32'(pd[7:0]), 32'(mq[0]));
    if (mq.size() > 1) checkOutput("pop_data1", 32'(pd[15:8]), 32'(mq[1]));
    checkOutput("free_slots", 32'(fs), 32'(DEPTH - mq.size()));
    checkOutput("overflow", 32'(ov), 32'(movf));
    checkOutput("drop_cnt", 32'(dc), 32'(mdrop));
  endtask

  // One clock of stimulus on the selected instance, then model update and full check.
  task automatic applyStimulus(input logic fl, input logic [1:0] pv,
                               input logic [7:0] d0, input logic [7:0] d1, input int pc);
    int         sz;
    int         excess;
    int         mmax;
    logic [1:0] exp_rdy, rdy;
    sz   = mq.size();
    mmax = ow_sel ? 3 : 255;
    exp_rdy[0] = ow_sel ? 1'b1 : (sz < DEPTH);
    exp_rdy[1] = ow_sel ? 1'b1 : (sz < DEPTH - 1);
    rdy = ow_sel ? ow_push_ready : bp_push_ready;
    checkOutput("push_ready", 32'(rdy), 32'(exp_rdy));
    idleInputs();
    if (ow_sel) begin
      ow_flush = fl; ow_push_valid = pv; ow_push_data = {d1, d0}; ow_pop_cnt = pc[1:0];
    end else begin
      bp_flush = fl; bp_push_valid = pv; bp_push_data = {d1, d0}; bp_pop_cnt = pc[1:0];
    end
    @(posedge clk);
    #1;
    idleInputs();
    movf = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      repeat (pc) void'(mq.pop_front());
      if (pv[0] && exp_rdy[0]) mq.push_back(d0);
      if (pv[1] && exp_rdy[1]) mq.push_back(d1);
      if (mq.size() > DEPTH) begin
        excess = mq.size() - DEPTH;
        repeat (excess) void'(mq.pop_front());
        movf  = 1'b1;
        mdrop = mdrop + excess;
        if (mdrop > mmax) mdrop = mmax;
      end
    end
    checkState();
  endtask

  task automatic doReset(input logic [1:0] pv);
    idleInputs();
    rst = 1'b1;
    if (ow_sel) begin ow_push_valid = pv; ow_push_data = 16'h5A5A; end
    else begin bp_push_valid = pv; bp_push_data = 16'h5A5A; end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idleInputs();
    mq.delete();
    mdrop = 0;
    movf  = 1'b0;
    checkState();
    checkOutput("rst_bp_ready", 32'(bp_push_ready), 32'h3);
    checkOutput("rst_ow_ready", 32'(ow_push_ready), 32'h3);
    checkOutput("rst_bp_drop", 32'(bp_drop_cnt), 32'h0);
    checkOutput("rst_ow_drop", 32'(ow_drop_cnt), 32'h0);
  endtask

  task automatic runRandom(input int n);
    int         sz, pc, sel;
    logic [1:0] pv;
    logic       fl;
    for (int k = 0; k < n; k++) begin
      sz  = mq.size();
      sel = $urandom_range(0, 3);
      pv  = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
      pc  = $urandom_range(0, (sz < 2) ? sz : 2);
      fl  = ($urandom_range(0, 49) == 0);
      applyStimulus(fl, pv, 8'($urandom), 8'($urandom), pc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mdrop  = 0;
    movf   = 1'b0;
    ow_sel = 1'b0;
    idleInputs();
    rst = 1'b1;

    // Backpressure instance: fill/drain, then limited acceptance near full.
    doReset(2'b00);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 2'b11, 8'(2*k), 8'(2*k+1), 0);
    checkOutput("fill_free0", 32'(bp_free_slots), 32'h0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 2'b00, 8'h0, 8'h0, 2);
    checkOutput("drain_valid", 32'(bp_valid), 32'h0);

    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 2'b11, 8'(8'h60 + 2*k), 8'(8'h61 + 2*k), 0);
    applyStimulus(1'b0, 2'b01, 8'h66, 8'h00, 0);
    applyStimulus(1'b0, 2'b11, 8'h70, 8'h71, 0);
    checkOutput("bp_free_full", 32'(bp_free_slots), 32'h0);
    applyStimulus(1'b0, 2'b11, 8'h72, 8'h73, 0);
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 1);
    applyStimulus(1'b0, 2'b11, 8'h80, 8'h81, 2);
    checkOutput("bp_free_popush", 32'(bp_free_slots), 32'h2);
    checkOutput("bp_no_drop", 32'(bp_drop_cnt), 32'h0);
    runRandom(500);

    doReset(2'b00);
    applyStimulus(1'b0, 2'b11, 8'h11, 8'h12, 0);
    applyStimulus(1'b0, 2'b11, 8'h13, 8'h14, 0);
    applyStimulus(1'b0, 2'b01, 8'h15, 8'h00, 0);
    applyStimulus(1'b1, 2'b11, 8'h16, 8'h17, 0);
    checkOutput("flush_valid", 32'(bp_valid), 32'h0);

    // Overwrite instance: overflow, overflow with pop, saturation of the 2-bit counter.
    ow_sel = 1'b1;
    doReset(2'b00);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 2'b11, 8'(2*k), 8'(2*k+1), 0);
    applyStimulus(1'b0, 2'b11, 8'hAA, 8'hBB, 0);
    checkOutput("ow_ovf", 32'(ow_overflow), 32'h1);
    checkOutput("ow_drop2", 32'(ow_drop_cnt), 32'h2);
    checkOutput("ow_lanes", 32'(ow_pop_data), 32'h0302);
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 0);
    checkOutput("ow_ovf_pulse", 32'(ow_overflow), 32'h0);
    applyStimulus(1'b0, 2'b11, 8'hCC, 8'hDD, 1);
    checkOutput("ow_drop3", 32'(ow_drop_cnt), 32'h3);
    checkOutput("ow_full", 32'(ow_free_slots), 32'h0);
    applyStimulus(1'b0, 2'b11, 8'hEE, 8'hFF, 0);
    checkOutput("ow_sat", 32'(ow_drop_cnt), 32'h3);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 2);
    runRandom(600);

    applyStimulus(1'b1, 2'b11, 8'h21, 8'h22, 0);
    checkOutput("ow_flush_drop", 32'(ow_drop_cnt), 32'h3);
    applyStimulus(1'b0, 2'b11, 8'h31, 8'h32, 0);
    doReset(2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
